ff_bist_checker: RTL and testbench

Synthesizable stimulus-and-response engine for single-bit flip-flop DUTs with asynchronous active-low reset. It drives pseudo-random data and reset patterns into the DUT, models the expected output cycle by cycle, and counts mismatches. It reports pass/fail in silicon or in FPGA bring-up, where a simulation-only pattern bench cannot run.

---
 rtl/ff_bist_pkg.sv | 29 ++
 rtl/lfsr16.sv | 45 ++++
 rtl/ff_bist_checker.sv | 148 ++++++++++++++
 tb/tb_ff_bist_checker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ff_bist_pkg
// Purpose : Shared types and constants for the flip-flop BIST checker. It
//           holds the FSM state encoding, the LFSR tap mask, the default seed,
//           the "no failure recorded" marker and the LFSR step function.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ff_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] NO_FAIL      = 16'hFFFF;

  // Fibonacci step: shift left, and the XOR of the tapped bits enters bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module  : lfsr16
// Purpose : 16-bit Fibonacci LFSR with synchronous load and enable. A zero
//           seed would lock the register up, so it is replaced by 16'h0001.
// Ports   : clk      - clock
//           rst      - asynchronous active-high reset (state <= seed)
//           load_i   - reload the seed on this edge
//           en_i     - advance one step on this edge
//           seed_i   - load value
//           state_o  - value the current pattern is taken from; this is the
//                      seed while load_i is high, else the register
// Revision: 1.0 - initial release
// ============================================================================
module lfsr16
  import ff_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] w_seed;
  logic [15:0] w_cur;
  logic [15:0] state_q;

  assign w_seed  = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
  // With load and enable together the register ends one step past the seed,
  // because the seed value itself is consumed as a pattern on that edge.
  assign w_cur   = load_i ? w_seed : state_q;
  assign state_o = w_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= w_seed;
    end else begin
      state_q <= en_i ? lfsr_step(w_cur) : w_cur;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ff_bist_checker.sv
`default_nettype none
// ============================================================================
// Module  : ff_bist_checker
// Purpose : Stimulus-and-response engine for a single-bit DFF with an
//           asynchronous active-low reset. It drives pseudo-random D/reset
//           patterns, models the expected Q, and counts mismatches.
// Ports   : clk, rst      - clock, asynchronous active-high reset
//           start         - run request (honoured in IDLE and DONE)
//           dut_d         - registered D drive to the DUT
//           dut_rst_n     - registered active-low reset drive to the DUT
//           dut_q         - DUT Q output
//           busy / done   - high in RUN / DONE
//           pass          - done and no mismatches
//           err_cnt       - saturating mismatch count
//           fail_idx      - pattern index of the first mismatch, FFFF if none
// Revision: 1.0 - initial release
// ============================================================================
module ff_bist_checker
  import ff_bist_pkg::*;
#(
  parameter int unsigned PATNUM = 100,
  parameter logic [15:0] SEED   = DEFAULT_SEED,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_d,
  output logic             dut_rst_n,
  input  logic             dut_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [15:0]      fail_idx
);

  localparam logic [15:0]      LAST_IDX = 16'(PATNUM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             dut_d_q, dut_d_d;
  logic             rstn_q, rstn_d;
  logic             m_q, m_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [15:0]      fail_q, fail_d;
  logic [15:0]      pat_idx_q, pat_idx_d;

  logic             w_load;
  logic             w_adv;
  logic [15:0]      w_lfsr;
  logic             w_exp_q;
  logic             w_mis;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_load),
    .en_i    (w_adv),
    .seed_i  (SEED),
    .state_o (w_lfsr)
  );

  // Expected Q includes the DUT's asynchronous clear while rst_n is low.
  assign w_exp_q = rstn_q ? m_q : 1'b0;
  assign w_mis   = (dut_q != w_exp_q);

  always_comb begin
    state_d   = state_q;
    dut_d_d   = dut_d_q;
    rstn_d    = rstn_q;
    err_d     = err_q;
    fail_d    = fail_q;
    pat_idx_d = pat_idx_q;
    w_load    = 1'b0;
    w_adv     = 1'b0;
    // The reference flop runs every edge from the values driven before it.
    m_d       = rstn_q ? dut_d_q : 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          w_load    = 1'b1;
          w_adv     = 1'b1;
          dut_d_d   = w_lfsr[0];
          rstn_d    = |w_lfsr[3:1];
          err_d     = '0;
          fail_d    = NO_FAIL;
          pat_idx_d = 16'd0;
        end
      end
      RUN: begin
        if (w_mis) begin
          if (err_q != CNT_MAX) begin
            err_d = err_q + CNT_W'(1);
          end
          if (fail_q == NO_FAIL) begin
            fail_d = pat_idx_q;
          end
        end
        if (pat_idx_q == LAST_IDX) begin
          state_d = DONE;
          dut_d_d = 1'b0;
          rstn_d  = 1'b0;
        end else begin
          w_adv     = 1'b1;
          dut_d_d   = w_lfsr[0];
          rstn_d    = |w_lfsr[3:1];
          pat_idx_d = pat_idx_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dut_d_q   <= 1'b0;
      rstn_q    <= 1'b0;
      m_q       <= 1'b0;
      err_q     <= '0;
      fail_q    <= NO_FAIL;
      pat_idx_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      dut_d_q   <= dut_d_d;
      rstn_q    <= rstn_d;
      m_q       <= m_d;
      err_q     <= err_d;
      fail_q    <= fail_d;
      pat_idx_q <= pat_idx_d;
    end
  end

  assign dut_d     = dut_d_q;
  assign dut_rst_n = rstn_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == '0);
  assign err_cnt   = err_q;
  assign fail_idx  = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_ff_bist_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_ff_bist_checker
// Purpose : Self-checking bench for ff_bist_checker. Four checkers run
//           against behavioural DFFs: a main 100-pattern instance whose DUT
//           can be golden, inverted or reset-disconnected; inverted DUTs on
//           a 10-pattern and a saturating 4-bit-counter instance; and a
//           golden DUT on an instance with the illegal zero seed.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ff_bist_checker;

  logic clk;
  logic rst;
  logic start0, start12;
  int   mode;  // 0 golden, 1 inverted Q, 2 reset ignored

  int total = 0;
  int bad   = 0;

  // ---------------- main instance ----------------
  logic       d0, r0, q0, busy0, done0, pass0;
  logic [7:0] err0;
  logic [15:0] fidx0;
  logic       g0, n0;

  ff_bist_checker #(.PATNUM(100), .SEED(16'hACE1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start0), .dut_d(d0), .dut_rst_n(r0),
    .dut_q(q0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_idx(fidx0)
  );

  always @(posedge clk or negedge r0) begin
    if (!r0) g0 <= 1'b0;
    else     g0 <= d0;
  end
  always @(posedge clk) n0 <= d0;
  assign q0 = (mode == 0) ? g0 : (mode == 1) ? ~g0 : n0;

  // ---------------- inverted DUT, PATNUM=10 ----------------
  logic       d1, r1, g1, busy1, done1, pass1;
  logic [7:0] err1;
  logic [15:0] fidx1;

  ff_bist_checker #(.PATNUM(10), .SEED(16'hACE1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start12), .dut_d(d1), .dut_rst_n(r1),
    .dut_q(~g1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_idx(fidx1)
  );
  always @(posedge clk or negedge r1) begin
    if (!r1) g1 <= 1'b0;
    else     g1 <= d1;
  end

  // ---------------- inverted DUT, CNT_W=4, PATNUM=20 ----------------
  logic       d2, r2, g2, busy2, done2, pass2;
  logic [3:0] err2;
  logic [15:0] fidx2;

  ff_bist_checker #(.PATNUM(20), .SEED(16'hACE1), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .start(start12), .dut_d(d2), .dut_rst_n(r2),
    .dut_q(~g2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .fail_idx(fidx2)
  );
  always @(posedge clk or negedge r2) begin
    if (!r2) g2 <= 1'b0;
    else     g2 <= d2;
  end

  // ---------------- golden DUT, zero seed, PATNUM=16 ----------------
  logic       d3, r3, g3, busy3, done3, pass3;
  logic [7:0] err3;
  logic [15:0] fidx3;

  ff_bist_checker #(.PATNUM(16), .SEED(16'h0000), .CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .start(start12), .dut_d(d3), .dut_rst_n(r3),
    .dut_q(g3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .fail_idx(fidx3)
  );
  always @(posedge clk or negedge r3) begin
    if (!r3) g3 <= 1'b0;
    else     g3 <= d3;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference pattern tables ----------------
  logic pd [100];
  logic pr [100];
  logic p3d [16];
  logic p3r [16];

  // Pattern k comes from the seed advanced k times; bit 0 is D, and the DUT
  // reset is asserted when bits 3..1 are all zero.
  function automatic int next_lfsr(input int s);
    int fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return ((s << 1) | fb) & 32'hFFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One run of the main instance. abort_at >= 0 asserts rst in the middle
  // of the cycle that drives that pattern and ends the run there.
  task automatic run0(input int md, input bit with_others, input int abort_at);
    int  exp_err;
    int  exp_fail;
    bit  prev_d, prev_r, expq, act, mis;
    mode = md;
    repeat ($urandom_range(0, 3)) step();
    start0 = 1'b1;
    if (with_others) start12 = 1'b1;
    step();
    start0  = 1'b0;
    start12 = 1'b0;
    exp_err  = 0;
    exp_fail = 16'hFFFF;
    prev_d   = 1'b0;
    prev_r   = 1'b0;
    for (int k = 0; k < 100; k++) begin
      chk("busy_run", {31'd0, busy0}, 32'd1);
      chk("dut_d", {31'd0, d0}, {31'd0, pd[k]});
      chk("dut_rst_n", {31'd0, r0}, {31'd0, pr[k]});
      if (with_others && k < 16) begin
        chk("zseed_d", {31'd0, d3}, {31'd0, p3d[k]});
        chk("zseed_rst_n", {31'd0, r3}, {31'd0, p3r[k]});
      end
      if (k == abort_at) begin
        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_dut_rst_n", {31'd0, r0}, 32'd0);
        chk("rst_dut_d", {31'd0, d0}, 32'd0);
        chk("rst_err", {24'd0, err0}, 32'd0);
        chk("rst_fidx", {16'd0, fidx0}, 32'hFFFF);
        chk("rst_pass", {31'd0, pass0}, 32'd0);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_idle", {31'd0, busy0}, 32'd0);
        return;
      end
      // Occasional start requests while running must have no effect.
      start0 = ($urandom_range(0, 7) == 0);
      step();
      start0 = 1'b0;
      expq = pr[k] ? (prev_r ? prev_d : 1'b0) : 1'b0;
      act  = (md == 0) ? expq : (md == 1) ? ~expq : prev_d;
      mis  = (act != expq);
      if (mis) begin
        if (exp_err < 255) exp_err++;
        if (exp_fail == 16'hFFFF) exp_fail = k;
      end
      chk("err_cnt", {24'd0, err0}, exp_err);
      chk("fail_idx", {16'd0, fidx0}, exp_fail);
      prev_d = pd[k];
      prev_r = pr[k];
    end
    chk("done_end", {31'd0, done0}, 32'd1);
    chk("busy_end", {31'd0, busy0}, 32'd0);
    chk("pass_end", {31'd0, pass0}, (exp_err == 0) ? 32'd1 : 32'd0);
    chk("dut_d_end", {31'd0, d0}, 32'd0);
    chk("dut_rst_n_end", {31'd0, r0}, 32'd0);
  endtask

  initial begin
    int s;
    rst     = 1'b1;
    start0  = 1'b0;
    start12 = 1'b0;
    mode    = 0;

    s = 16'hACE1;
    for (int k = 0; k < 100; k++) begin
      pd[k] = s[0];
      pr[k] = (s[3:1] != 3'b000);
      s = next_lfsr(s);
    end
    s = 16'h0001;
    for (int k = 0; k < 16; k++) begin
      p3d[k] = s[0];
      p3r[k] = (s[3:1] != 3'b000);
      s = next_lfsr(s);
    end

    // Reset values appear before any clock edge.
    #3;
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    chk("reset_done", {31'd0, done0}, 32'd0);
    chk("reset_pass", {31'd0, pass0}, 32'd0);
    chk("reset_dut_d", {31'd0, d0}, 32'd0);
    chk("reset_dut_rst_n", {31'd0, r0}, 32'd0);
    chk("reset_err", {24'd0, err0}, 32'd0);
    chk("reset_fidx", {16'd0, fidx0}, 32'hFFFF);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("idle_busy", {31'd0, busy0}, 32'd0);

    run0(0, 1'b1, -1);

    chk("inv10_done", {31'd0, done1}, 32'd1);
    chk("inv10_err", {24'd0, err1}, 32'd10);
    chk("inv10_fidx", {16'd0, fidx1}, 32'd0);
    chk("inv10_pass", {31'd0, pass1}, 32'd0);
    chk("sat_done", {31'd0, done2}, 32'd1);
    chk("sat_err", {28'd0, err2}, 32'd15);
    chk("sat_fidx", {16'd0, fidx2}, 32'd0);
    chk("sat_pass", {31'd0, pass2}, 32'd0);
    chk("zseed_done", {31'd0, done3}, 32'd1);
    chk("zseed_pass", {31'd0, pass3}, 32'd1);
    chk("zseed_err", {24'd0, err3}, 32'd0);

    run0(1, 1'b0, -1);
    run0(2, 1'b0, -1);
    run0(1, 1'b0, 5);
    run0(0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
